// File: rtl/axi_wr_burst_sched.sv
// Burst scheduler: splits a write job into AXI INCR bursts (<= MAX_BURST beats, no 4 KB crossing),
// throttled to MAX_OUTST unacknowledged bursts. Optional statistics counters: AXI_WR_SCHED_STATS_EN.
module axi_wr_burst_sched #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int MAX_OUTST  = 4,
   parameter int LEN_WIDTH  = 24
) (
   input  logic                  axi_aclk,
   input  logic                  axi_areset,
   input  logic                  job_start,
   input  logic [ADDR_WIDTH-1:0] job_addr,
   input  logic [LEN_WIDTH-1:0]  job_beats,
   input  logic                  job_abort,
   output logic                  job_busy,
   output logic                  job_done,
   output logic                  job_err,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [7:0]            cmd_len,
   input  logic                  bresp_valid,
   input  logic [1:0]            bresp,
   output logic [31:0]           stat_bursts,
   output logic [15:0]           stat_errs
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int OFS = $clog2(BPB);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LEN_WIDTH-1:0]    rem_q, rem_after;
   logic [8:0]              len_q, len_c;
   logic [7:0]              len_m1_q;
   logic [3:0]              outst_q, outst_d;
   logic                    err_q, abort_q;
   logic                    hs, b_ok, b_err;
   logic [12:0]             room;

   assign hs        = (state_q == S_ISSUE) && cmd_ready;
   // Responses with nothing outstanding are stray and must not touch the count or the error flag.
   assign b_ok      = bresp_valid && (outst_q != 4'd0);
   assign b_err     = b_ok && (bresp != 2'b00);
   assign rem_after = rem_q - LEN_WIDTH'(len_q);
   assign room      = (13'd4096 - {1'b0, addr_q[11:0]}) >> OFS;

   assign cmd_addr  = addr_q;
   assign cmd_len   = len_m1_q;

   // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      len_c = 9'(MAX_BURST);
      if (32'(rem_q) < 32'(len_c)) len_c = 9'(rem_q);
      if (32'(room) < 32'(len_c))  len_c = 9'(room);
   end

   always_comb begin
      outst_d = outst_q;
      if (hs && !b_ok)      outst_d = outst_q + 4'd1;
      else if (!hs && b_ok) outst_d = outst_q - 4'd1;
   end

   always_comb begin
      state_d   = state_q;
      job_busy  = 1'b0;
      job_done  = 1'b0;
      job_err   = 1'b0;
      cmd_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (job_start) state_d = (job_beats == '0) ? S_DONE : S_CALC;
         end
         S_CALC: begin
            job_busy = 1'b1;
            if (job_abort)                     state_d = S_DRAIN;
            else if (outst_q < 4'(MAX_OUTST))  state_d = S_ISSUE;
         end
         S_ISSUE: begin
            job_busy  = 1'b1;
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               state_d = (rem_after != '0 && !abort_q && !job_abort) ? S_CALC : S_DRAIN;
            end
         end
         S_DRAIN: begin
            job_busy = 1'b1;
            if (outst_d == 4'd0) state_d = S_DONE;
         end
         S_DONE: begin
            job_done = 1'b1;
            job_err  = err_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         len_q    <= '0;
         len_m1_q <= '0;
         outst_q  <= '0;
         err_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         outst_q <= outst_d;
         if (b_err) err_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (job_start) begin
                  addr_q  <= job_addr & ~ADDR_WIDTH'(BPB - 1);
                  rem_q   <= job_beats;
                  err_q   <= 1'b0;
                  abort_q <= 1'b0;
               end
            end
            S_CALC: begin
               len_q    <= len_c;
               len_m1_q <= 8'(len_c - 9'd1);
               if (job_abort) err_q <= 1'b1;
            end
            S_ISSUE: begin
               if (job_abort) begin
                  abort_q <= 1'b1;
                  err_q   <= 1'b1;
               end
               if (cmd_ready) begin
                  addr_q <= addr_q + (ADDR_WIDTH'(len_q) << OFS);
                  rem_q  <= rem_after;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AXI_WR_SCHED_STATS_EN
   logic [31:0] bursts_q;
   logic [15:0] errs_q;

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         bursts_q <= '0;
         errs_q   <= '0;
      end else begin
         if (hs) bursts_q <= bursts_q + 32'd1;
         if (b_err && errs_q != 16'hFFFF) errs_q <= errs_q + 16'd1;
      end
   end

   assign stat_bursts = bursts_q;
   assign stat_errs   = errs_q;
`else
   assign stat_bursts = '0;
   assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Randomized self-checking bench for axi_wr_burst_sched: expected bursts come from a split model,
// B responses from a randomized responder that tracks unacknowledged bursts.
module tb_axi_wr_burst_sched;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MB  = 16;
   localparam int MO  = 4;
   localparam int LW  = 24;
   localparam int BPB = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          job_start, job_abort, job_busy, job_done, job_err;
   logic [AW-1:0] job_addr;
   logic [LW-1:0] job_beats;
   logic          cmd_valid, cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic          bresp_valid;
   logic [1:0]    bresp;
   logic [31:0]   stat_bursts;
   logic [15:0]   stat_errs;

   always #5 clk = ~clk;

   axi_wr_burst_sched #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .MAX_OUTST(MO), .LEN_WIDTH(LW)
   ) dut (
      .axi_aclk(clk), .axi_areset(rst),
      .job_start(job_start), .job_addr(job_addr), .job_beats(job_beats), .job_abort(job_abort),
      .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .bresp_valid(bresp_valid), .bresp(bresp),
      .stat_bursts(stat_bursts), .stat_errs(stat_errs)
   );

   int      n_tests = 0;
   int      n_fail  = 0;
   longint  model_bursts = 0;
   int      model_errs   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      job_start   = 1'b0;
      job_abort   = 1'b0;
      cmd_ready   = 1'b0;
      bresp_valid = 1'b0;
      bresp       = 2'b00;
   endtask

   task automatic check_stats(input string tag);
`ifdef AXI_WR_SCHED_STATS_EN
      check({tag, "_stat_bursts"}, stat_bursts, 64'(model_bursts % 64'h1_0000_0000));
      check({tag, "_stat_errs"}, stat_errs, 64'(model_errs));
`else
      check({tag, "_stat_bursts"}, stat_bursts, 0);
      check({tag, "_stat_errs"}, stat_errs, 0);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, job_busy, 0);
      check({tag, "_done"}, job_done, 0);
      check({tag, "_err"}, job_err, 0);
      check({tag, "_cmd_valid"}, cmd_valid, 0);
      check({tag, "_cmd_addr"}, cmd_addr, 0);
      check({tag, "_cmd_len"}, cmd_len, 0);
      check_stats(tag);
   endtask

   // One job from start to done. hold: no B responses before that cycle; abort_cmd: abort while
   // the Nth command is first presented (0 = never); strict: bursts must come every 2 cycles.
   task automatic run_job(input string tag, input logic [AW-1:0] addr, input int beats,
                          input int ready_pct, input int err_pct, input int err_idx,
                          input int hold, input int abort_cmd, input bit strict, input bit poke_start);
      logic [AW-1:0] eq_addr[$];
      logic [7:0]    eq_len[$];
      logic [AW-1:0] a, held_addr;
      logic [7:0]    held_len;
      int            r, l, room;
      int            pending, n_cmd, n_resp, n_seen, first_obs, last_hs, last_resp;
      int            abort_obs, hs_after_abort, ready_low, obs;
      bit            exp_err, aborted, prev_valid, done_seen, e;

      a = addr & ~AW'(BPB - 1);
      r = beats;
      while (r > 0) begin
         room = (4096 - int'(a % 4096)) / BPB;
         l = r;
         if (l > MB)   l = MB;
         if (l > room) l = room;
         eq_addr.push_back(a);
         eq_len.push_back(8'(l - 1));
         a = a + AW'(l * BPB);
         r = r - l;
      end

      pending = 0; n_cmd = 0; n_resp = 0; n_seen = 0; first_obs = 0; last_hs = 0;
      last_resp = 0; abort_obs = 0; hs_after_abort = 0; ready_low = 0;
      exp_err = 0; aborted = 0; prev_valid = 0; done_seen = 0;
      held_addr = '0; held_len = '0;

      job_addr  = addr;
      job_beats = LW'(beats);
      job_start = 1'b1;
      tick();
      job_start = 1'b0;
      job_addr  = $urandom;
      job_beats = LW'($urandom_range(1, 50));

      obs = 1;
      while (!done_seen && obs <= 4000) begin
         job_abort = 1'b0;
         job_start = poke_start && ($urandom_range(15) == 0);
         if (job_done) begin
            done_seen = 1;
            check({tag, "_err"}, job_err, exp_err);
            check({tag, "_busy_at_done"}, job_busy, 0);
            check({tag, "_pending_at_done"}, pending, 0);
            if (aborted) check({tag, "_cmds_after_abort"}, hs_after_abort, 1);
            else         check({tag, "_cmds_missing"}, eq_addr.size(), 0);
            if (beats == 0) begin
               check({tag, "_zero_done_latency_ok"}, obs <= 2, 1);
               check({tag, "_zero_no_cmd"}, n_cmd, 0);
            end else begin
               check({tag, "_first_cmd_latency"}, first_obs, 2);
               check({tag, "_done_after_last_bresp"}, obs - last_resp, 1);
            end
         end else begin
            if (cmd_valid && first_obs == 0) first_obs = obs;
            if (cmd_valid && !prev_valid) begin
               n_seen++;
               if (n_seen == abort_cmd && !aborted) begin
                  job_abort = 1'b1;
                  aborted   = 1;
                  exp_err   = 1;
                  abort_obs = obs;
                  ready_low = 6;
               end
            end
            if (cmd_valid && prev_valid) begin
               check({tag, "_held_addr"}, cmd_addr, held_addr);
               check({tag, "_held_len"}, cmd_len, held_len);
            end

            if (ready_low > 0) begin
               cmd_ready = 1'b0;
               ready_low--;
            end else begin
               cmd_ready = ($urandom_range(99) < ready_pct);
            end

            bresp_valid = 1'b0;
            bresp       = 2'b00;
            if (pending > 0 && obs >= hold && (strict || $urandom_range(2) == 0)) begin
               e = (n_resp == err_idx) || (int'($urandom_range(99)) < err_pct);
               bresp_valid = 1'b1;
               bresp       = e ? 2'(($urandom_range(2)) + 1) : 2'b00;
               if (e) begin
                  exp_err = 1;
                  if (model_errs < 16'hFFFF) model_errs++;
               end
               pending--;
               n_resp++;
               last_resp = obs;
            end

            if (obs == hold) check({tag, "_stall_at_max_outst"}, n_cmd, MO);

            if (cmd_valid && cmd_ready) begin
               if (eq_addr.size() > 0) begin
                  check({tag, "_cmd_addr"}, cmd_addr, eq_addr.pop_front());
                  check({tag, "_cmd_len"}, cmd_len, eq_len.pop_front());
               end else begin
                  check({tag, "_unexpected_cmd"}, 1, 0);
               end
               if (strict && last_hs > 0) check({tag, "_burst_gap"}, obs - last_hs, 2);
               if (aborted && obs > abort_obs) hs_after_abort++;
               last_hs = obs;
               n_cmd++;
               pending++;
               model_bursts++;
               check({tag, "_outst_limit"}, pending <= MO, 1);
               prev_valid = 0;
            end else begin
               prev_valid = cmd_valid;
               held_addr  = cmd_addr;
               held_len   = cmd_len;
            end
            tick();
            obs++;
         end
      end
      idle_inputs();
      if (!done_seen) check({tag, "_done_timeout"}, 0, 1);
      check_stats(tag);
      tick();
      check({tag, "_done_one_cycle"}, job_done, 0);
   endtask

   initial begin
      idle_inputs();
      job_addr  = '0;
      job_beats = '0;
      rst       = 1'b1;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      run_job("split40", 32'h0000_1000, 40, 100, 0, -1, 0, 0, 1, 0);
      run_job("cross4k", 32'h0000_1FF0, 10, 100, 0, -1, 0, 0, 0, 0);
      run_job("outst", 32'h0000_0000, 128, 100, 0, -1, 30, 0, 0, 0);
      run_job("bresp_err", 32'h0000_2000, 16, 100, 0, 1, 0, 0, 0, 0);
      run_job("abort", 32'h0000_3000, 64, 100, 0, -1, 0, 2, 0, 0);
      run_job("zero", 32'h0000_0040, 0, 100, 0, -1, 0, 0, 0, 0);
      run_job("unaligned", 32'h0000_0FFF, 3, 60, 0, -1, 0, 0, 0, 1);

      // reset in the middle of a job: everything returns to reset values at once
      job_addr  = 32'h0000_5000;
      job_beats = LW'(200);
      job_start = 1'b1;
      tick();
      job_start = 1'b0;
      cmd_ready = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      tick();
      model_bursts = 0;
      model_errs   = 0;
      check_reset_outputs("midjob_reset");
      rst = 1'b0;
      idle_inputs();
      tick();
      run_job("after_reset", 32'h0000_6000, 50, 100, 0, -1, 0, 0, 0, 0);

      for (int j = 0; j < 25; j++) begin
         run_job("rand", AW'($urandom), int'($urandom_range(1, 300)), int'($urandom_range(30, 100)),
                 ($urandom_range(1) == 1) ? 8 : 0, -1, 0, int'($urandom_range(0, 3)), 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
